// File: rtl/riscv_pkg.sv
// Shared core constants; the data-memory defaults live here so the core and
// its memory agree on depth and access latency.
package riscv_pkg;

   localparam int MEM_WORDS_DEF   = 1024;
   localparam int MEM_LATENCY_DEF = 2;
   localparam int MEM_BE_W        = 4;

endpackage

// File: rtl/riscv_byte_ram.sv
// Word-wide RAM with per-byte write enables and a registered read port.
// Read data holds its value on cycles without a read.
module riscv_byte_ram
   import riscv_pkg::*;
#(
   parameter int WORDS = MEM_WORDS_DEF,
   localparam int AW   = $clog2(WORDS)
) (
   input  logic                clk_i,
   input  logic                en_i,
   input  logic                we_i,
   input  logic [MEM_BE_W-1:0] be_i,
   input  logic [AW-1:0]       idx_i,
   input  logic [31:0]         wd_i,
   output logic [31:0]         rd_o
);

   logic [31:0] r_mem [WORDS];
   logic [31:0] r_rd;

   // NOTE: the array has no reset on purpose; a reset term would stop it mapping onto block RAM.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int k = 0; k < MEM_BE_W; k++) begin
               if (be_i[k]) r_mem[idx_i][8*k +: 8] <= wd_i[8*k +: 8];
            end
         end else begin
            r_rd <= r_mem[idx_i];
         end
      end
   end

   assign rd_o = r_rd;

endmodule

// File: rtl/riscv_data_mem.sv
// LSU-facing data memory: captures one request, waits LATENCY cycles, then
// commits the write or returns the read word with a one-cycle ready pulse.
module riscv_data_mem
   import riscv_pkg::*;
#(
   parameter int WORDS   = MEM_WORDS_DEF,
   parameter int LATENCY = MEM_LATENCY_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                mem_req_i,
   input  logic                mem_we_i,
   input  logic [MEM_BE_W-1:0] mem_be_i,
   input  logic [31:0]         mem_addr_i,
   input  logic [31:0]         mem_wd_i,
   output logic [31:0]         mem_rd_o,
   output logic                mem_ready_o
);

   localparam int AW        = $clog2(WORDS);
   localparam int CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam bit FAST      = (LATENCY == 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
   localparam logic [32:0]   ADDR_LIM = 33'(WORDS * 4);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } mem_state_t;

   mem_state_t          r_state;
   logic [CW-1:0]       r_cnt;
   logic                r_we;
   logic [MEM_BE_W-1:0] r_be;
   logic [31:0]         r_addr;
   logic [31:0]         r_wd;
   logic                r_rd_zero;

   logic                w_accept;
   logic                w_commit;
   logic                w_we;
   logic [MEM_BE_W-1:0] w_be;
   logic [31:0]         w_addr;
   logic [31:0]         w_wd;
   logic                w_in_range;
   logic [31:0]         w_ram_rd;

   // With LATENCY = 1 the commit edge is the capture edge, so the RAM is fed straight from the bus.
   assign w_accept   = (r_state == ST_IDLE) && mem_req_i;
   assign w_we       = (r_state == ST_IDLE) ? mem_we_i   : r_we;
   assign w_be       = (r_state == ST_IDLE) ? mem_be_i   : r_be;
   assign w_addr     = (r_state == ST_IDLE) ? mem_addr_i : r_addr;
   assign w_wd       = (r_state == ST_IDLE) ? mem_wd_i   : r_wd;
   assign w_in_range = ({1'b0, w_addr} < ADDR_LIM);
   assign w_commit   = !rst_i && ((FAST && w_accept) ||
                                  (r_state == ST_WAIT && r_cnt == CW'(1)));

   riscv_byte_ram #(
      .WORDS (WORDS)
   ) u_ram (
      .clk_i (clk_i),
      .en_i  (w_commit && w_in_range),
      .we_i  (w_we),
      .be_i  (w_be),
      .idx_i (w_addr[2 +: AW]),
      .wd_i  (w_wd),
      .rd_o  (w_ram_rd)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_be      <= '0;
         r_addr    <= '0;
         r_wd      <= '0;
         r_rd_zero <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (mem_req_i) begin
                  r_we    <= mem_we_i;
                  r_be    <= mem_be_i;
                  r_addr  <= mem_addr_i;
                  r_wd    <= mem_wd_i;
                  r_cnt   <= CNT_INIT;
                  r_state <= FAST ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) r_state <= ST_RESP;
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
         // Out-of-range reads report zero; writes leave the previous read word visible.
         if (w_commit && !w_we) r_rd_zero <= !w_in_range;
      end
   end

   assign mem_ready_o = (r_state == ST_RESP);
   assign mem_rd_o    = r_rd_zero ? 32'h0 : w_ram_rd;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench: a LATENCY=2 instance driven from a vector table plus
// hand sequences, and a LATENCY=1 instance for back-to-back timing.
module tb_riscv_data_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        req  [2];
   logic        we   [2];
   logic [3:0]  be   [2];
   logic [31:0] addr [2];
   logic [31:0] wd   [2];
   logic [31:0] rd   [2];
   logic        rdy  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_data_mem #(.WORDS(1024), .LATENCY(2)) u_l2 (
      .clk_i(clk), .rst_i(rst), .mem_req_i(req[0]), .mem_we_i(we[0]), .mem_be_i(be[0]),
      .mem_addr_i(addr[0]), .mem_wd_i(wd[0]), .mem_rd_o(rd[0]), .mem_ready_o(rdy[0])
   );

   riscv_data_mem #(.WORDS(16), .LATENCY(1)) u_l1 (
      .clk_i(clk), .rst_i(rst), .mem_req_i(req[1]), .mem_we_i(we[1]), .mem_be_i(be[1]),
      .mem_addr_i(addr[1]), .mem_wd_i(wd[1]), .mem_rd_o(rd[1]), .mem_ready_o(rdy[1])
   );

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete transaction on instance s; checks ready latency, read word and pulse width.
   task automatic txn(input int s, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
      int lat;
      int k;
      lat = (s == 0) ? 2 : 1;
      @(negedge clk);
      req[s] = 1'b1; we[s] = w; be[s] = b; addr[s] = a; wd[s] = d;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rdy[s] && k < 8);
      check($sformatf("%s latency", tag), k, lat);
      check($sformatf("%s rd", tag), rd[s], exp_rd);
      req[s] = 1'b0;
      @(negedge clk);
      check($sformatf("%s pulse", tag), {31'b0, rdy[s]}, 32'h0);
   endtask

   vec_t vecs [16];
   int   pulses;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 4'hF, 32'h10,   32'hA5A5_1234, 32'h0};
      vecs[1]  = '{1'b0, 4'hF, 32'h10,   32'h0,         32'hA5A5_1234};
      vecs[2]  = '{1'b1, 4'hF, 32'h10,   32'h1122_3344, 32'hA5A5_1234};
      vecs[3]  = '{1'b1, 4'h8, 32'h13,   32'h7700_0000, 32'hA5A5_1234};
      vecs[4]  = '{1'b0, 4'hF, 32'h10,   32'h0,         32'h7722_3344};
      vecs[5]  = '{1'b0, 4'hF, 32'h1000, 32'h0,         32'h0};
      vecs[6]  = '{1'b1, 4'hF, 32'h0,    32'hCAFE_F00D, 32'h0};
      vecs[7]  = '{1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF, 32'h0};
      vecs[8]  = '{1'b0, 4'hF, 32'h0,    32'h0,         32'hCAFE_F00D};
      vecs[9]  = '{1'b1, 4'hF, 32'h4,    32'h0102_0304, 32'hCAFE_F00D};
      vecs[10] = '{1'b1, 4'h0, 32'h4,    32'hFFFF_FFFF, 32'hCAFE_F00D};
      vecs[11] = '{1'b0, 4'hF, 32'h4,    32'h0,         32'h0102_0304};
      vecs[12] = '{1'b1, 4'hF, 32'hFFC,  32'h0BAD_C0DE, 32'h0102_0304};
      vecs[13] = '{1'b0, 4'hF, 32'hFFF,  32'h0,         32'h0BAD_C0DE};
      vecs[14] = '{1'b1, 4'h5, 32'h11,   32'h00AA_00BB, 32'h0BAD_C0DE};
      vecs[15] = '{1'b0, 4'hF, 32'h10,   32'h0,         32'h77AA_33BB};

      for (int s = 0; s < 2; s++) begin
         req[s] = 1'b0; we[s] = 1'b0; be[s] = 4'h0; addr[s] = 32'h0; wd[s] = 32'h0;
      end
      rst = 1'b1;
      #12;
      for (int s = 0; s < 2; s++) begin
         check($sformatf("reset ready[%0d]", s), {31'b0, rdy[s]}, 32'h0);
         check($sformatf("reset rd[%0d]", s), rd[s], 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++)
         txn(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd,
             $sformatf("vec%0d", i));

      // Reset in WAIT of a write: no commit, no pulse, outputs cleared.
      txn(0, 1'b1, 4'hF, 32'h20, 32'h5555_5555, 32'h77AA_33BB, "pre_rst_wr");
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h20; wd[0] = 32'h9999_9999;
      @(negedge clk);
      rst = 1'b1; req[0] = 1'b0;
      #1;
      check("rst_wait ready", {31'b0, rdy[0]}, 32'h0);
      check("rst_wait rd", rd[0], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rdy[0]) pulses++;
      end
      check("rst_wait no pulse", pulses, 0);
      txn(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h5555_5555, "rst_wait old data");

      // Bus activity during WAIT must not disturb the captured read.
      txn(0, 1'b1, 4'hF, 32'h30, 32'h0A0A_0A0A, 32'h5555_5555, "pre_tog_wr");
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h30; wd[0] = 32'h0;
      @(negedge clk);
      check("tog wait ready", {31'b0, rdy[0]}, 32'h0);
      req[0] = 1'b0; we[0] = 1'b1; addr[0] = 32'h10; wd[0] = 32'h0;
      #1 req[0] = 1'b1;
      #1 req[0] = 1'b0;
      @(negedge clk);
      check("tog ready", {31'b0, rdy[0]}, 32'h1);
      check("tog rd", rd[0], 32'h0A0A_0A0A);
      we[0] = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rdy[0]) pulses++;
      end
      check("tog single pulse", pulses, 0);
      txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h77AA_33BB, "tog no write");

      // LATENCY=1 back-to-back reads with req held.
      txn(1, 1'b1, 4'hF, 32'h0, 32'h1111_1111, 32'h0, "l1 wr0");
      txn(1, 1'b1, 4'hF, 32'h4, 32'h2222_2222, 32'h0, "l1 wr1");
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
      @(negedge clk);
      check("b2b ready T+1", {31'b0, rdy[1]}, 32'h1);
      check("b2b rd0", rd[1], 32'h1111_1111);
      addr[1] = 32'h4;
      @(negedge clk);
      check("b2b ready T+2", {31'b0, rdy[1]}, 32'h0);
      @(negedge clk);
      check("b2b ready T+3", {31'b0, rdy[1]}, 32'h1);
      check("b2b rd1", rd[1], 32'h2222_2222);
      req[1] = 1'b0;
      @(negedge clk);
      check("b2b ready T+4", {31'b0, rdy[1]}, 32'h0);
      txn(1, 1'b0, 4'hF, 32'h40, 32'h0, 32'h0, "l1 oor rd");
      txn(1, 1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF, 32'h0, "l1 oor wr");
      txn(1, 1'b0, 4'hF, 32'h0, 32'h0, 32'h1111_1111, "l1 word0 intact");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
